// File: rtl/gd_step_ctrl_if.sv
// Evaluator handshake bundle: the controller drives request and operands,
// the evaluator answers with a level done, a Q24.8 result and an overflow flag.
interface gd_step_ctrl_if;
    logic        eval_start;
    logic [15:0] eval_a;
    logic [15:0] eval_b;
    logic [15:0] eval_c;
    logic [15:0] eval_d;
    logic        eval_done;
    logic [31:0] eval_z;
    logic        eval_ovf;

    modport master (
        output eval_start, eval_a, eval_b, eval_c, eval_d,
        input  eval_done, eval_z, eval_ovf
    );

    modport slave (
        input  eval_start, eval_a, eval_b, eval_c, eval_d,
        output eval_done, eval_z, eval_ovf
    );
endinterface

// File: rtl/gd_step_ctrl.sv
// 4D gradient-descent sequencer: forward-difference gradient from one base and four
// +h evaluations per iteration, saturating Q8.8 update, final base evaluation at exit.
module gd_step_ctrl #(
    parameter int H_SHIFT     = 4,
    parameter int LR_SHIFT    = 6,
    parameter int MAX_ITER    = 64,
    parameter int ITER_W      = 8,
    parameter int EPS         = 0,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          a_init,
    input  logic [15:0]          b_init,
    input  logic [15:0]          c_init,
    input  logic [15:0]          d_init,
    gd_step_ctrl_if.master       eval,
    output logic [15:0]          a_out,
    output logic [15:0]          b_out,
    output logic [15:0]          c_out,
    output logic [15:0]          d_out,
    output logic [31:0]          z_out,
    output logic [ITER_W-1:0]    iter_count,
    output logic                 busy,
    output logic                 done,
    output logic                 converged,
    output logic                 overflow,
    output logic                 error
);

    localparam int          TW    = $clog2(TIMEOUT_CYC + 1);
    localparam int          SHIFT = LR_SHIFT - H_SHIFT;
    localparam logic [16:0] H_LSB = 17'(1 << (8 - H_SHIFT));

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_REQ, S_REL, S_UPDATE, S_DONE, S_ERROR
    } state_t;

    state_t              state;
    logic signed [15:0]  x [4];
    logic signed [31:0]  f0;
    logic signed [31:0]  fk [4];
    logic [2:0]          idx;
    logic                final_eval;
    logic [TW-1:0]       tmo;

    logic [15:0]         op [4];
    logic                op_ovf;
    logic signed [15:0]  newx [4];
    logic                upd_ovf;
    logic                conv;
    logic [16:0]         psum;
    logic [16:0]         xsum;
    logic [16:0]         dabs;
    logic signed [31:0]  diff;
    logic signed [31:0]  sh;
    logic signed [15:0]  dl;

    // Next perturbed operand set (coordinate idx gets +h) and the parallel update step.
    always_comb begin
        op_ovf  = 1'b0;
        upd_ovf = 1'b0;
        conv    = 1'b1;
        psum    = '0;
        xsum    = '0;
        dabs    = '0;
        diff    = '0;
        sh      = '0;
        dl      = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            op[k]   = x[k];
            newx[k] = x[k];
        end
        for (int unsigned k = 0; k < 4; k++) begin
            if (2'(k) == idx[1:0]) begin
                psum = {x[k][15], x[k]} + H_LSB;
                if (psum[16] != psum[15]) begin
                    op[k]  = 16'h7FFF;
                    op_ovf = 1'b1;
                end else begin
                    op[k] = psum[15:0];
                end
            end
            diff = fk[k] - f0;
            sh   = diff >>> SHIFT;
            if (sh[31:15] != {17{sh[31]}}) begin
                dl      = sh[31] ? 16'sh8000 : 16'sh7FFF;
                upd_ovf = 1'b1;
            end else begin
                dl = sh[15:0];
            end
            xsum = {x[k][15], x[k]} - {dl[15], dl};
            if (xsum[16] != xsum[15]) begin
                newx[k] = xsum[16] ? 16'sh8000 : 16'sh7FFF;
                upd_ovf = 1'b1;
            end else begin
                newx[k] = xsum[15:0];
            end
            dabs = dl[15] ? (17'd0 - {dl[15], dl}) : {dl[15], dl};
            if (dabs > 17'(EPS))
                conv = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            for (int unsigned k = 0; k < 4; k++) begin
                x[k]  <= '0;
                fk[k] <= '0;
            end
            f0              <= '0;
            idx             <= '0;
            final_eval      <= 1'b0;
            tmo             <= '0;
            eval.eval_start <= 1'b0;
            eval.eval_a     <= '0;
            eval.eval_b     <= '0;
            eval.eval_c     <= '0;
            eval.eval_d     <= '0;
            a_out           <= '0;
            b_out           <= '0;
            c_out           <= '0;
            d_out           <= '0;
            z_out           <= '0;
            iter_count      <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            converged       <= 1'b0;
            overflow        <= 1'b0;
            error           <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x[0]       <= a_init;
                        x[1]       <= b_init;
                        x[2]       <= c_init;
                        x[3]       <= d_init;
                        iter_count <= '0;
                        converged  <= 1'b0;
                        overflow   <= 1'b0;
                        error      <= 1'b0;
                        final_eval <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    idx             <= '0;
                    eval.eval_a     <= x[0];
                    eval.eval_b     <= x[1];
                    eval.eval_c     <= x[2];
                    eval.eval_d     <= x[3];
                    eval.eval_start <= 1'b1;
                    tmo             <= '0;
                    state           <= S_REQ;
                end
                S_REQ: begin
                    if (eval.eval_done) begin
                        if (idx == 3'd0) f0 <= eval.eval_z;
                        else             fk[idx[1:0] - 2'd1] <= eval.eval_z;
                        overflow        <= overflow | eval.eval_ovf;
                        eval.eval_start <= 1'b0;
                        tmo             <= '0;
                        state           <= S_REL;
                    end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
                        eval.eval_start <= 1'b0;
                        error           <= 1'b1;
                        done            <= 1'b1;
                        busy            <= 1'b0;
                        state           <= S_ERROR;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_REL: begin
                    if (!eval.eval_done) begin
                        if (final_eval) begin
                            a_out <= x[0];
                            b_out <= x[1];
                            c_out <= x[2];
                            d_out <= x[3];
                            z_out <= f0;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else if (idx != 3'd4) begin
                            idx             <= idx + 1'b1;
                            eval.eval_a     <= op[0];
                            eval.eval_b     <= op[1];
                            eval.eval_c     <= op[2];
                            eval.eval_d     <= op[3];
                            overflow        <= overflow | op_ovf;
                            eval.eval_start <= 1'b1;
                            tmo             <= '0;
                            state           <= S_REQ;
                        end else begin
                            state <= S_UPDATE;
                        end
                    end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_ERROR;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_UPDATE: begin
                    for (int unsigned k = 0; k < 4; k++)
                        x[k] <= newx[k];
                    iter_count <= iter_count + 1'b1;
                    overflow   <= overflow | upd_ovf;
                    if (conv || (iter_count + 1'b1) == ITER_W'(MAX_ITER)) begin
                        converged  <= conv;
                        final_eval <= 1'b1;
                    end
                    idx             <= '0;
                    eval.eval_a     <= newx[0];
                    eval.eval_b     <= newx[1];
                    eval.eval_c     <= newx[2];
                    eval.eval_d     <= newx[3];
                    eval.eval_start <= 1'b1;
                    tmo             <= '0;
                    state           <= S_REQ;
                end
                S_DONE, S_ERROR: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gd_step_ctrl.sv
// Bench for gd_step_ctrl: stub evaluator with 2-cycle latency plus an
// algorithm-level reference model of the descent run.
module tb_gd_step_ctrl;

    localparam int MAXI = 3;
    localparam int HS   = 4;
    localparam int LRS  = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a_init = '0, b_init = '0, c_init = '0, d_init = '0;
    logic [15:0] a_out, b_out, c_out, d_out;
    logic [31:0] z_out;
    logic [7:0]  iter_count;
    logic        busy, done, converged, overflow, error;

    gd_step_ctrl_if eval_if ();

    gd_step_ctrl #(
        .H_SHIFT(HS), .LR_SHIFT(LRS), .MAX_ITER(MAXI), .ITER_W(8), .EPS(0), .TIMEOUT_CYC(255)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_init(a_init), .b_init(b_init), .c_init(c_init), .d_init(d_init),
        .eval(eval_if),
        .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out), .z_out(z_out),
        .iter_count(iter_count), .busy(busy), .done(done), .converged(converged),
        .overflow(overflow), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int mode = 0;       // 0 sext(a), 1 const 0x500, 2 -sext(a), 3 weighted quadratic, 4 never done
    int w[4] = '{0, 0, 0, 0};
    bit ovf_inj = 1'b0;
    int pulses = 0;
    logic st_q = 1'b0;
    logic [1:0] lat = '0;

    function automatic int f_eval(input int md, input int p0, input int p1, input int p2, input int p3);
        case (md)
            0:       return p0;
            1:       return 32'h500;
            2:       return -p0;
            default: return w[0]*p0 + w[1]*p1 + w[2]*p2 + w[3]*p3 + ((p0*p0) >>> 10);
        endcase
    endfunction

    // Stub evaluator: result two cycles after request, done held until request drops.
    always @(posedge clk) begin
        if (rst) begin
            eval_if.eval_done <= 1'b0;
            eval_if.eval_z    <= '0;
            eval_if.eval_ovf  <= 1'b0;
            lat               <= '0;
        end else if (eval_if.eval_start && !eval_if.eval_done && mode != 4) begin
            if (lat == 2'd1) begin
                eval_if.eval_done <= 1'b1;
                eval_if.eval_z    <= f_eval(mode, int'($signed(eval_if.eval_a)), int'($signed(eval_if.eval_b)),
                                            int'($signed(eval_if.eval_c)), int'($signed(eval_if.eval_d)));
                eval_if.eval_ovf  <= ovf_inj;
                lat               <= '0;
            end else begin
                lat <= lat + 1'b1;
            end
        end else if (!eval_if.eval_start) begin
            eval_if.eval_done <= 1'b0;
            lat               <= '0;
        end
    end

    always @(posedge clk) begin
        st_q <= eval_if.eval_start;
        if (eval_if.eval_start && !st_q) pulses <= pulses + 1;
    end

    int m_x[4];
    int m_z, m_iter, m_tx;
    bit m_conv, m_ovf;

    // Reference: plain forward-difference descent on integers.
    task automatic model(input int md, input int i0, input int i1, input int i2, input int i3);
        int x[4], p[4], nx[4];
        int f0, fk, d;
        bit allz;
        x = '{i0, i1, i2, i3};
        m_ovf = ovf_inj; m_tx = 0; m_iter = 0; m_conv = 1'b0;
        while (1) begin
            f0 = f_eval(md, x[0], x[1], x[2], x[3]); m_tx++;
            allz = 1'b1;
            for (int k = 0; k < 4; k++) begin
                p = x;
                p[k] = x[k] + (1 << (8 - HS));
                if (p[k] > 32767) begin p[k] = 32767; m_ovf = 1'b1; end
                fk = f_eval(md, p[0], p[1], p[2], p[3]); m_tx++;
                d = (fk - f0) >>> (LRS - HS);
                if (d > 32767)  begin d = 32767;  m_ovf = 1'b1; end
                if (d < -32768) begin d = -32768; m_ovf = 1'b1; end
                nx[k] = x[k] - d;
                if (nx[k] > 32767)  begin nx[k] = 32767;  m_ovf = 1'b1; end
                if (nx[k] < -32768) begin nx[k] = -32768; m_ovf = 1'b1; end
                if (d != 0) allz = 1'b0;
            end
            x = nx;
            m_iter++;
            if (allz || m_iter == MAXI) begin
                m_conv = allz;
                break;
            end
        end
        m_z = f_eval(md, x[0], x[1], x[2], x[3]); m_tx++;
        m_x = x;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                       input logic [15:0] ic, input logic [15:0] id,
                       input bit hold_start, input bit busy_pulse);
        int snap, n;
        model(mode, int'($signed(ia)), int'($signed(ib)), int'($signed(ic)), int'($signed(id)));
        a_init = ia; b_init = ib; c_init = ic; d_init = id;
        snap = pulses;
        start = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        n = 0;
        while (!done && n < 4000) begin
            if (busy_pulse && n == 10) start = 1'b1;
            if (busy_pulse && n == 11) start = 1'b0;
            tick();
            n++;
        end
        chk({tag, "/done"},      32'(done), 32'd1);
        chk({tag, "/busy"},      32'(busy), 32'd0);
        chk({tag, "/error"},     32'(error), 32'd0);
        chk({tag, "/a_out"},     32'(a_out), 32'(m_x[0][15:0]));
        chk({tag, "/b_out"},     32'(b_out), 32'(m_x[1][15:0]));
        chk({tag, "/c_out"},     32'(c_out), 32'(m_x[2][15:0]));
        chk({tag, "/d_out"},     32'(d_out), 32'(m_x[3][15:0]));
        chk({tag, "/z_out"},     z_out, m_z);
        chk({tag, "/iter"},      32'(iter_count), 32'(m_iter));
        chk({tag, "/converged"}, 32'(converged), 32'(m_conv));
        chk({tag, "/overflow"},  32'(overflow), 32'(m_ovf));
        chk({tag, "/tx"},        32'(pulses - snap), 32'(m_tx));
    endtask

    initial begin
        int n, snap;
        logic [15:0] r[4];

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst/eval_start", 32'(eval_if.eval_start), 32'd0);
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/done", 32'(done), 32'd0);
        chk("rst/z_out", z_out, 32'd0);
        chk("rst/iter", 32'(iter_count), 32'd0);

        mode = 0;
        run("t1", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        chk("t1/a_const", 32'(a_out), 32'h0000FFF4);
        chk("t1/z_const", z_out, 32'hFFFFFFF4);
        tick();

        mode = 1;
        run("t2", 16'h0100, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
        chk("t2/conv_const", 32'(converged), 32'd1);
        chk("t2/z_const", z_out, 32'h500);
        tick();

        mode = 2;
        run("t3", 16'h7FFE, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        chk("t3/a_const", 32'(a_out), 32'h00007FFF);
        chk("t3/ovf_const", 32'(overflow), 32'd1);
        tick();

        mode = 1;
        ovf_inj = 1'b1;
        run("t_ovfin", 16'h0010, 16'h0020, 16'h0030, 16'h0040, 1'b0, 1'b0);
        ovf_inj = 1'b0;
        tick();

        // start held after completion must not restart the run
        mode = 1;
        run("t_hold", 16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b1, 1'b0);
        snap = pulses;
        for (int i = 0; i < 5; i++) tick();
        chk("hold/done_kept", 32'(done), 32'd1);
        chk("hold/no_restart", 32'(pulses - snap), 32'd0);
        start = 1'b0;
        tick();
        chk("hold/done_clr", 32'(done), 32'd0);
        chk("hold/busy_clr", 32'(busy), 32'd0);

        // timeout: evaluator never answers
        mode = 4;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!eval_if.eval_start && n < 10) begin tick(); n++; end
        n = 0;
        while (eval_if.eval_start && n < 400) begin n++; tick(); end
        chk("tmo/req_cycles", 32'(n), 32'd255);
        chk("tmo/error", 32'(error), 32'd1);
        chk("tmo/done", 32'(done), 32'd1);
        chk("tmo/busy", 32'(busy), 32'd0);
        tick();
        chk("tmo/idle_done", 32'(done), 32'd0);

        // reset while a request is outstanding
        mode = 0;
        a_init = 16'h0040;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!eval_if.eval_start && n < 10) begin tick(); n++; end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst/eval_start", 32'(eval_if.eval_start), 32'd0);
        chk("midrst/busy", 32'(busy), 32'd0);
        chk("midrst/a_out", 32'(a_out), 32'd0);
        chk("midrst/z_out", z_out, 32'd0);
        chk("midrst/error", 32'(error), 32'd0);
        tick(); tick();
        run("t_after_rst", 16'h0040, 16'hFFC0, 16'h0000, 16'h0001, 1'b0, 1'b0);
        tick();

        // randomized points over a weighted quadratic surface
        mode = 3;
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < 4; k++) begin
                w[k] = int'($urandom_range(0, 6)) - 3;
                r[k] = (t % 3 == 0) ? 16'(16'h7FF0 + $urandom_range(0, 15)) : 16'($urandom);
            end
            run($sformatf("rnd%0d", t), r[0], r[1], r[2], r[3], 1'b0, t[0]);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
